fpu_cmd_frontend: RTL and testbench
===================================

// Module: fpu_cmd_frontend
// PURPOSE
//  Bus-side front end for the FPU core, generalised in operand width and command depth. Host writes operands A/B
//  byte-wise over the 8-bit CPU bus, then an opcode; each opcode write snapshots {op,A,B} into a command queue.
//  A dispatch FSM feeds the core one command at a time and holds the result and flags for readback.
//  Completion is signalled on cmd_end (IRQ) until acknowledged. Sits between the Sol-1 bus decode and the FPU datapath.
// PARAMETERS
//  OP_W      32  operand/result width in bits; 32 or 64 (multiple of 8)
//  DEPTH     4   command queue entries; power of 2, >=2
//  TIMEOUT   1024  max cycles in WAIT before abort; 0 disables the timeout
// PORTS
//  clk          in   1       clock
//  arst         in   1       reset, synchronous, active-high
//  databus_in   in   8       write data
//  databus_out  out  8       read data, registered
//  addr         in   6       register address
//  cs           in   1       chip select, active-low
//  rd           in   1       read strobe, active-low
//  wr           in   1       write strobe, active-low
//  end_ack      in   1       host acknowledge of cmd_end
//  cmd_end      out  1       command complete / IRQ, level
//  busy         out  1       FSM not IDLE or queue not empty
//  core_op      out  4       opcode to core (codes as pa_fpu)
//  core_a       out  OP_W    operand A to core
//  core_b       out  OP_W    operand B to core
//  core_start   out  1       one-cycle start pulse
//  core_done    in   1       one-cycle completion pulse from core
//  core_result  in   OP_W    result, valid with core_done
//  core_flags   in   4       {inv,dz,ovf,unf}, valid with core_done
// BEHAVIOUR
//  Map (NB=OP_W/8): A bytes 0x00+i, B bytes 0x08+i, RESULT bytes 0x18+i (i<NB, little-endian); CMD 0x10 (low nibble=op);
//   STATUS 0x11 = {core_flags[3:0], tmo, qovf, cmd_end, busy}. Unmapped reads return 0x00; unmapped writes ignored.
//  Write: one write per strobe, on the cycle cs=0 and wr=0 with wr=1 the previous cycle (falling-edge detect on registered wr).
//  Read: when cs=0 and rd=0, databus_out <= reg[addr] next cycle; else databus_out <= 0x00.
//  CMD write: pushes {op,A,B} if queue not full; if full and no pop same cycle -> dropped, qovf<=1 (sticky).
//   Full with simultaneous pop -> push accepted. A/B stay unchanged after the push (re-usable for back-to-back ops).
//  STATUS write: bit2=1 clears qovf, bit3=1 clears tmo; other bits read-only.
//  FSM: IDLE -> ISSUE when queue non-empty (pop, drive core_op/a/b) -> core_start=1 for exactly that one cycle ->
//   WAIT until core_done -> DONE: latch result/flags, cmd_end<=1 -> IDLE on the cycle end_ack=1 (cmd_end<=0 then).
//   end_ack held high before entering DONE does not count; it must be sampled high while in DONE.
//  Timeout: WAIT cycle counter; at TIMEOUT cycles -> DONE, result<=0, flags<=0, tmo<=1. A late core_done is ignored.
//  core_done outside WAIT ignored. core_a/b/op held stable from ISSUE until leaving WAIT.
//  Latency: CMD write strobe to core_start = 2 cycles when IDLE and queue empty; core_done to cmd_end = 1 cycle.
//  Next command is not issued until end_ack; result registers are never overwritten unacknowledged.
//  Reset: all outputs 0 (databus_out=0x00, cmd_end=0, busy=0, core_start=0, core_*=0); queue emptied, A/B/RESULT/STATUS
//   cleared, FSM->IDLE. Reset mid-WAIT aborts with no cmd_end; subsequent core_done ignored.
// TESTING
//  Reset: arst 2 cycles -> all outputs 0, STATUS reads 0x00, RESULT bytes read 0x00.
//  Div: A=0x4331E148, B=0x42C7FAE1, CMD=op_div; model core answers 0x3FE3B58C after 20 cycles ->
//   core_start 1 pulse, cmd_end=1, RESULT reads 48?->8C,B5,E3,3F; end_ack -> cmd_end=0, busy=0.
//  Queue: DEPTH+1 CMD writes while core stalled -> last dropped, STATUS.qovf=1; exactly DEPTH start pulses; write 0x04 clears qovf.
//  Ack gating: hold end_ack=1 continuously from before DONE -> cmd_end still asserts and clears 1 cycle later; held off -> no new core_start.
//  Timeout: TIMEOUT=16, core never responds -> cmd_end at WAIT+16 cycles, STATUS.tmo=1, RESULT=0; late core_done ignored.
//  Reset mid-WAIT: arst during WAIT, then core_done -> cmd_end stays 0, busy=0, queue empty.

Source files
------------

// File: rtl/fpu_cmd_frontend.sv
// fpu_cmd_frontend: 8-bit host register file -> {op,A,B} command queue -> one-at-a-time FPU dispatch.
// CMD strobe to core_start is 2 cycles when idle; CMD writes into a full queue are dropped and flagged in qovf.
module fpu_cmd_frontend #(
    parameter int OP_W    = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            arst,
    input  logic [7:0]      databus_in,
    output logic [7:0]      databus_out,
    input  logic [5:0]      addr,
    input  logic            cs,
    input  logic            rd,
    input  logic            wr,
    input  logic            end_ack,
    output logic            cmd_end,
    output logic            busy,
    output logic [3:0]      core_op,
    output logic [OP_W-1:0] core_a,
    output logic [OP_W-1:0] core_b,
    output logic            core_start,
    input  logic            core_done,
    input  logic [OP_W-1:0] core_result,
    input  logic [3:0]      core_flags
);
    localparam int NB = OP_W / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 4 + 2 * OP_W;
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          state_q;
    logic            wr_q;
    logic [OP_W-1:0] a_q, b_q, result_q, core_a_q, core_b_q;
    logic [3:0]      flags_q, core_op_q;
    logic            tmo_q, qovf_q, cmd_end_q, core_start_q;
    logic [7:0]      databus_q, rd_data_d;
    logic [TW-1:0]   tmo_cnt_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW:0]     count_q;

    logic       wr_stb, cmd_wr, stat_wr, q_empty, q_full, pop, push, tmo_hit;
    logic [7:0] status;

    assign wr_stb  = !cs && !wr && wr_q;
    assign cmd_wr  = wr_stb && (addr == 6'h10);
    assign stat_wr = wr_stb && (addr == 6'h11);
    assign q_empty = (count_q == '0);
    assign q_full  = (count_q == FULL_CNT);
    assign pop     = (state_q == S_IDLE) && !q_empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts the write.
    assign push    = cmd_wr && (!q_full || pop);
    assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST);
    assign busy    = (state_q != S_IDLE) || !q_empty;
    assign status  = {flags_q, tmo_q, qovf_q, cmd_end_q, busy};

    always_comb begin
        rd_data_d = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (addr == 6'(i))      rd_data_d = a_q[8*i +: 8];
            if (addr == 6'(8 + i))  rd_data_d = b_q[8*i +: 8];
            if (addr == 6'(24 + i)) rd_data_d = result_q[8*i +: 8];
        end
        if (addr == 6'h11) rd_data_d = status;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_q      <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            qovf_q    <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            databus_q <= 8'h00;
        end else begin
            wr_q      <= wr;
            databus_q <= (!cs && !rd) ? rd_data_d : 8'h00;
            if (wr_stb) begin
                for (int i = 0; i < NB; i++) begin
                    if (addr == 6'(i))     a_q[8*i +: 8] <= databus_in;
                    if (addr == 6'(8 + i)) b_q[8*i +: 8] <= databus_in;
                end
            end
            if (stat_wr && databus_in[2]) qovf_q <= 1'b0;
            if (cmd_wr && !push)          qovf_q <= 1'b1;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {databus_in[3:0], a_q, b_q};
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q      <= S_IDLE;
            core_op_q    <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_start_q <= 1'b0;
            cmd_end_q    <= 1'b0;
            result_q     <= '0;
            flags_q      <= '0;
            tmo_q        <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            if (stat_wr && databus_in[3]) tmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!q_empty) begin
                        {core_op_q, core_a_q, core_b_q} <= mem_q[rptr_q];
                        core_start_q <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    core_start_q <= 1'b0;
                    tmo_cnt_q    <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        result_q  <= core_result;
                        flags_q   <= core_flags;
                        cmd_end_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (tmo_hit) begin
                        result_q  <= '0;
                        flags_q   <= '0;
                        tmo_q     <= 1'b1;
                        cmd_end_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    // Only an ack sampled here counts, so a held-high ack still yields a one-cycle cmd_end.
                    if (end_ack) begin
                        cmd_end_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign databus_out = databus_q;
    assign cmd_end     = cmd_end_q;
    assign core_op     = core_op_q;
    assign core_a      = core_a_q;
    assign core_b      = core_b_q;
    assign core_start  = core_start_q;

endmodule

// File: tb/tb_fpu_cmd_frontend.sv
// Bench for fpu_cmd_frontend: register access table, then directed dispatch, queue, ack, timeout and reset sequences.
// dut_t shares all inputs but uses a short timeout so the abort path is reachable.
module tb_fpu_cmd_frontend;
    localparam int OP_W = 32;
    localparam int DEPTH = 4;
    localparam logic [5:0] A_CMD  = 6'h10;
    localparam logic [5:0] A_STAT = 6'h11;
    localparam logic [5:0] A_RES  = 6'h18;
    localparam logic [7:0] OP_DIV = 8'h03;

    typedef struct {
        logic       is_wr;
        logic [5:0] addr;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic arst, cs, rd, wr, end_ack, core_done;
    logic [7:0] databus_in;
    logic [5:0] addr;
    logic [OP_W-1:0] core_result;
    logic [3:0] core_flags;

    logic [7:0] databus_out, t_databus_out;
    logic cmd_end, busy, core_start, t_cmd_end, t_busy, t_core_start;
    logic [3:0] core_op, t_core_op;
    logic [OP_W-1:0] core_a, core_b, t_core_a, t_core_b;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [3:0] seen_ops [$];

    fpu_cmd_frontend #(.OP_W(OP_W), .DEPTH(DEPTH), .TIMEOUT(1024)) dut (
        .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out), .addr(addr),
        .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end), .busy(busy),
        .core_op(core_op), .core_a(core_a), .core_b(core_b), .core_start(core_start),
        .core_done(core_done), .core_result(core_result), .core_flags(core_flags)
    );

    fpu_cmd_frontend #(.OP_W(OP_W), .DEPTH(DEPTH), .TIMEOUT(16)) dut_t (
        .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(t_databus_out), .addr(addr),
        .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(t_cmd_end), .busy(t_busy),
        .core_op(t_core_op), .core_a(t_core_a), .core_b(t_core_b), .core_start(t_core_start),
        .core_done(core_done), .core_result(core_result), .core_flags(core_flags)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            start_cnt++;
            seen_ops.push_back(core_op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        arst = 1'b1;
        cs = 1'b1; rd = 1'b1; wr = 1'b1; end_ack = 1'b0; core_done = 1'b0;
        repeat (2) tick();
        arst = 1'b0;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
        addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
        tick();
        wr = 1'b1; cs = 1'b1;
        tick();
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [7:0] d, output logic [7:0] dt);
        addr = a; cs = 1'b0; rd = 1'b0;
        tick();
        d = databus_out;
        dt = t_databus_out;
        cs = 1'b1; rd = 1'b1;
    endtask

    // Waits for the target start count (landing in WAIT), answers, optionally acknowledges.
    task automatic serve(input int target, input logic [31:0] res, input logic ack);
        int n = 0;
        while (start_cnt < target && n < 50) begin
            tick();
            n++;
        end
        check("serve_start_seen", n < 50, 1);
        core_result = res; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("serve_cmd_end", cmd_end, 1);
        if (ack) begin
            end_ack = 1'b1;
            tick();
            end_ack = 1'b0;
            check("serve_ack_clear", cmd_end, 0);
        end
    endtask

    initial begin
        vec_t vecs [18];
        logic [7:0] rv, rvt;
        logic [31:0] exp_res;
        logic [3:0] exp_ops [6];
        int n, base, sidx;

        vecs[0]  = '{1'b1, 6'h00, 8'h48, 8'h00};
        vecs[1]  = '{1'b1, 6'h01, 8'hE1, 8'h00};
        vecs[2]  = '{1'b1, 6'h02, 8'h31, 8'h00};
        vecs[3]  = '{1'b1, 6'h03, 8'h43, 8'h00};
        vecs[4]  = '{1'b1, 6'h08, 8'hE1, 8'h00};
        vecs[5]  = '{1'b1, 6'h09, 8'hFA, 8'h00};
        vecs[6]  = '{1'b1, 6'h0A, 8'hC7, 8'h00};
        vecs[7]  = '{1'b1, 6'h0B, 8'h42, 8'h00};
        vecs[8]  = '{1'b0, 6'h00, 8'h00, 8'h48};
        vecs[9]  = '{1'b0, 6'h03, 8'h00, 8'h43};
        vecs[10] = '{1'b0, 6'h09, 8'h00, 8'hFA};
        vecs[11] = '{1'b0, 6'h0B, 8'h00, 8'h42};
        vecs[12] = '{1'b0, 6'h04, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 6'h3F, 8'h00, 8'h00};
        vecs[14] = '{1'b0, 6'h11, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 6'h18, 8'h00, 8'h00};
        vecs[16] = '{1'b1, 6'h20, 8'h55, 8'h00};
        vecs[17] = '{1'b0, 6'h20, 8'h00, 8'h00};
        exp_ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};

        addr = 6'h00; databus_in = 8'h00; core_result = '0; core_flags = 4'h0;
        do_reset();

        // Reset state
        check("rst_databus_out", databus_out, 8'h00);
        check("rst_cmd_end", cmd_end, 0);
        check("rst_busy", busy, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_op", core_op, 0);
        check("rst_core_a", core_a, 0);
        check("rst_core_b", core_b, 0);
        bus_read(A_STAT, rv, rvt);
        check("rst_status", rv, 8'h00);
        bus_read(A_RES + 6'd3, rv, rvt);
        check("rst_result3", rv, 8'h00);

        // Register map vectors
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].dat);
            else begin
                bus_read(vecs[i].addr, rv, rvt);
                check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), rv, vecs[i].exp);
            end
        end
        tick();
        check("idle_databus_zero", databus_out, 8'h00);

        // Division: start 2 cycles after strobe, core answers 20 cycles after start
        base = start_cnt;
        bus_write(A_CMD, OP_DIV);
        check("div_start_latency", core_start, 1);
        check("div_core_op", core_op, 4'h3);
        check("div_core_a", core_a, 32'h4331E148);
        check("div_core_b", core_b, 32'h42C7FAE1);
        tick();
        check("div_start_one_cycle", core_start, 0);
        repeat (18) tick();
        core_result = 32'h3FE3B58C; core_flags = 4'h0; core_done = 1'b1;
        check("div_cmd_end_before", cmd_end, 0);
        tick();
        core_done = 1'b0;
        check("div_cmd_end", cmd_end, 1);
        check("div_busy", busy, 1);
        check("div_start_pulses", start_cnt - base, 1);
        exp_res = 32'h3FE3B58C;
        for (int i = 0; i < 4; i++) begin
            bus_read(A_RES + 6'(i), rv, rvt);
            check($sformatf("div_result_b%0d", i), rv, exp_res[8*i +: 8]);
        end
        bus_read(6'h00, rv, rvt);
        check("div_a_retained", rv, 8'h48);
        bus_read(A_STAT, rv, rvt);
        check("div_status", rv, 8'h03);
        end_ack = 1'b1;
        tick();
        end_ack = 1'b0;
        check("div_ack_cmd_end", cmd_end, 0);
        check("div_ack_busy", busy, 0);
        core_result = 32'hDEADBEEF; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("stray_done_cmd_end", cmd_end, 0);
        bus_read(A_RES, rv, rvt);
        check("stray_done_result", rv, 8'h8C);

        // Queue: hold FSM in DONE, fill DEPTH entries, next write dropped
        do_reset();
        base = start_cnt; sidx = seen_ops.size(); core_flags = 4'h5;
        bus_write(A_CMD, 8'h01);
        serve(base + 1, 32'h11, 1'b0);
        for (int k = 2; k <= 6; k++) bus_write(A_CMD, 8'(k));
        bus_read(A_STAT, rv, rvt);
        check("q_status_ovf", rv, 8'h57);
        check("q_held_no_start", start_cnt - base, 1);
        bus_write(A_STAT, 8'h04);
        bus_read(A_STAT, rv, rvt);
        check("q_ovf_cleared", rv, 8'h53);
        end_ack = 1'b1;
        tick();
        end_ack = 1'b0;
        bus_write(A_CMD, 8'h07);
        bus_read(A_STAT, rv, rvt);
        check("q_full_pop_push_ok", rv, 8'h51);
        for (int j = 2; j <= 6; j++) serve(base + j, 32'(j), 1'b1);
        check("q_start_pulses", start_cnt - base, 6);
        for (int k = 0; k < 6; k++) begin
            if (sidx + k < seen_ops.size()) check($sformatf("q_op_order%0d", k), seen_ops[sidx + k], exp_ops[k]);
            else check($sformatf("q_op_missing%0d", k), 0, 1);
        end
        check("q_drained_busy", busy, 0);
        bus_read(A_STAT, rv, rvt);
        check("q_final_status", rv, 8'h50);

        // Ack held high from before DONE
        do_reset();
        base = start_cnt;
        end_ack = 1'b1;
        bus_write(A_CMD, 8'h01);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("ack_held_cmd_end_set", cmd_end, 1);
        tick();
        check("ack_held_cmd_end_clr", cmd_end, 0);
        check("ack_held_busy", busy, 0);
        end_ack = 1'b0;
        repeat (3) tick();
        check("ack_held_no_restart", start_cnt - base, 1);

        // Timeout on the short-timeout instance
        do_reset();
        core_flags = 4'h0;
        bus_write(A_CMD, 8'h02);
        check("tmo_start", t_core_start, 1);
        n = 0;
        while (!t_cmd_end && n < 40) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 17);
        bus_read(A_STAT, rv, rvt);
        check("tmo_status", rvt, 8'h0B);
        core_result = 32'hA5A5A5A5; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        bus_read(A_RES, rv, rvt);
        check("tmo_result_b0", rvt, 8'h00);
        bus_read(A_RES + 6'd3, rv, rvt);
        check("tmo_result_b3", rvt, 8'h00);
        check("tmo_cmd_end_held", t_cmd_end, 1);
        end_ack = 1'b1;
        tick();
        end_ack = 1'b0;
        bus_read(A_STAT, rv, rvt);
        check("tmo_sticky", rvt, 8'h08);
        bus_write(A_STAT, 8'h08);
        bus_read(A_STAT, rv, rvt);
        check("tmo_cleared", rvt, 8'h00);

        // Reset in the middle of WAIT
        do_reset();
        base = start_cnt;
        bus_write(A_CMD, 8'h01);
        tick();
        arst = 1'b1;
        tick();
        arst = 1'b0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (3) tick();
        check("rstw_cmd_end", cmd_end, 0);
        check("rstw_busy", busy, 0);
        check("rstw_core_a", core_a, 0);
        check("rstw_starts", start_cnt - base, 1);
        bus_read(A_STAT, rv, rvt);
        check("rstw_status", rv, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
